// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry: builds a packed BCD number one decimal digit at a time from a
// keypad code stream and hands it downstream with a valid/ready handshake.
// Codes: 0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC BACKSPACE, 0xD-0xF invalid.
// Optional feature macro: BCD_ENTRY_BACKSPACE_EN (enables BACKSPACE; otherwise
// 0xC is treated as an invalid code).
module bcd_digit_entry #(
    parameter int DECLEN = 9,
    parameter int CNTW   = $clog2(DECLEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DECLEN*4-1:0]   out_bcd,
    output logic [CNTW-1:0]       out_ndig,
    output logic                  err
);

    typedef enum logic [0:0] {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] MAX_NDIG = CNTW'(DECLEN);

    localparam logic [3:0] CODE_ENTER = 4'hA;
    localparam logic [3:0] CODE_CLEAR = 4'hB;
`ifdef BCD_ENTRY_BACKSPACE_EN
    localparam logic [3:0] CODE_BKSP  = 4'hC;
`endif

    state_t                state_q, state_d;
    logic [DECLEN*4-1:0]   bcd_q, bcd_d;
    logic [CNTW-1:0]       ndig_q, ndig_d;
    logic                  err_q, err_d;

    logic                  xfer;

    // handshake flags follow the state register directly
    always_comb begin
        in_ready  = (state_q == ENTRY);
        out_valid = (state_q == HOLD);
        xfer      = in_valid && (state_q == ENTRY);
        out_bcd   = bcd_q;
        out_ndig  = ndig_q;
        err       = err_q;
    end

    // next-state, digit shift register and error pulse
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        ndig_d  = ndig_q;
        err_d   = 1'b0;

        unique case (state_q)
            ENTRY: begin
                if (xfer) begin
                    if (in_code <= 4'd9) begin
                        if (ndig_q == MAX_NDIG) begin
                            err_d = 1'b1;
                        end else if (!(ndig_q == '0 && in_code == 4'd0)) begin
                            // leading zeros are swallowed so ndig counts significant digits
                            bcd_d  = {bcd_q[DECLEN*4-5:0], in_code};
                            ndig_d = ndig_q + CNTW'(1);
                        end
                    end else if (in_code == CODE_ENTER) begin
                        state_d = HOLD;
                    end else if (in_code == CODE_CLEAR) begin
                        bcd_d  = '0;
                        ndig_d = '0;
`ifdef BCD_ENTRY_BACKSPACE_EN
                    end else if (in_code == CODE_BKSP) begin
                        if (ndig_q != '0) begin
                            bcd_d  = {4'h0, bcd_q[DECLEN*4-1:4]};
                            ndig_d = ndig_q - CNTW'(1);
                        end
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ENTRY;
                    bcd_d   = '0;
                    ndig_d  = '0;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            bcd_q   <= '0;
            ndig_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            ndig_q  <= ndig_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry (DECLEN=9): decimal reference model, expected
// outputs queued per cycle and compared after the clock edge.
module tb_bcd_digit_entry;

    localparam int DECLEN = 9;
    localparam int CNTW   = $clog2(DECLEN + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_code;
    logic                 out_valid;
    logic                 out_ready;
    logic [DECLEN*4-1:0]  out_bcd;
    logic [CNTW-1:0]      out_ndig;
    logic                 err;

    bcd_digit_entry #(.DECLEN(DECLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_ndig(out_ndig), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DECLEN*4-1:0] bcd;
        logic [CNTW-1:0]     ndig;
        logic                err;
        logic                valid;
        logic                ready;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    // reference model: number kept as an integer value plus digit count
    longint unsigned m_val;
    int              m_nd;
    bit              m_hold;
    bit              m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DECLEN*4-1:0] to_bcd(input longint unsigned v);
        logic [DECLEN*4-1:0] r;
        longint unsigned     t;
        r = '0;
        t = v;
        for (int i = 0; i < DECLEN; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.bcd   = to_bcd(m_val);
        e.ndig  = CNTW'(m_nd);
        e.err   = m_err;
        e.valid = m_hold;
        e.ready = !m_hold;
        return e;
    endfunction

    // advance the model by one clock edge with the given inputs
    task automatic model_edge(input bit iv, input logic [3:0] code, input bit ordy);
        m_err = 1'b0;
        if (m_hold) begin
            if (ordy) begin
                m_hold = 1'b0;
                m_val  = 0;
                m_nd   = 0;
            end
        end else if (iv) begin
            if (code <= 4'd9) begin
                if (m_nd == DECLEN) m_err = 1'b1;
                else if (m_nd == 0 && code == 4'd0) ;
                else begin
                    m_val = m_val * 10 + longint'(code);
                    m_nd++;
                end
            end else if (code == 4'hA) begin
                m_hold = 1'b1;
            end else if (code == 4'hB) begin
                m_val = 0;
                m_nd  = 0;
`ifdef BCD_ENTRY_BACKSPACE_EN
            end else if (code == 4'hC) begin
                if (m_nd > 0) begin
                    m_val = m_val / 10;
                    m_nd--;
                end
`endif
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    function automatic void model_reset();
        m_val  = 0;
        m_nd   = 0;
        m_hold = 1'b0;
        m_err  = 1'b0;
    endfunction

    // one clock cycle: drive, queue expectation, clock, pop and compare
    task automatic cyc(input string tag, input bit iv, input logic [3:0] code, input bit ordy);
        exp_t e;
        in_valid  = iv;
        in_code   = code;
        out_ready = ordy;
        model_edge(iv, code, ordy);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".bcd"},   64'(out_bcd),   64'(e.bcd));
        chk({tag, ".ndig"},  64'(out_ndig),  64'(e.ndig));
        chk({tag, ".err"},   64'(err),       64'(e.err));
        chk({tag, ".valid"}, 64'(out_valid), 64'(e.valid));
        chk({tag, ".ready"}, 64'(in_ready),  64'(e.ready));
    endtask

    task automatic send(input string tag, input logic [3:0] code);
        cyc(tag, 1'b1, code, 1'b0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 4'h0;
        out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst.bcd",   64'(out_bcd),   64'h0);
        chk("rst.ndig",  64'(out_ndig),  64'h0);
        chk("rst.valid", 64'(out_valid), 64'h0);
        chk("rst.err",   64'(err),       64'h0);
        chk("rst.ready", 64'(in_ready),  64'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: commit 123, hold 3 cycles, then handshake
        send("t1.d1", 4'h1);
        send("t1.d2", 4'h2);
        send("t1.d3", 4'h3);
        send("t1.ent", 4'hA);
        chk("t1.commit", 64'(out_bcd), 64'h000000123);
        idle("t1.hold", 3);
        cyc("t1.hs", 1'b0, 4'h0, 1'b1);
        chk("t1.after_hs", 64'(in_ready), 64'h1);

        // 2: ten nines, overflow err, invalid code err
        for (int i = 0; i < 10; i++) send("t2.nine", 4'h9);
        chk("t2.full", 64'(out_bcd), 64'h999999999);
        idle("t2.errclr", 1);
        send("t2.inv", 4'hE);
        idle("t2.errclr2", 1);

        // 3: leading zeros, then clear
        send("t3.clr0", 4'hB);
        send("t3.z0", 4'h0);
        send("t3.z1", 4'h0);
        send("t3.d5", 4'h5);
        send("t3.d7", 4'h7);
        send("t3.d8", 4'h8);
        send("t3.clr", 4'hB);

        // 4: backspace (or invalid 0xC)
        send("t4.d4", 4'h4);
        send("t4.d5", 4'h5);
        send("t4.d6", 4'h6);
        send("t4.bs", 4'hC);
        idle("t4.idle", 1);
        send("t4.clr", 4'hB);
        send("t4.bs0", 4'hC);

        // 5: digit held on in_valid during HOLD must wait for the handshake
        send("t5.d8", 4'h8);
        send("t5.ent", 4'hA);
        cyc("t5.blk0", 1'b1, 4'h9, 1'b0);
        cyc("t5.blk1", 1'b1, 4'h9, 1'b0);
        cyc("t5.hs", 1'b1, 4'h9, 1'b1);
        cyc("t5.acc", 1'b1, 4'h9, 1'b0);
        idle("t5.once", 1);
        chk("t5.val", 64'(out_bcd), 64'h9);

        // 6: async reset in the middle of HOLD
        send("t6.clr", 4'hB);
        send("t6.d3", 4'h3);
        send("t6.ent", 4'hA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.async_valid", 64'(out_valid), 64'h0);
        chk("t6.async_bcd",   64'(out_bcd),   64'h0);
        chk("t6.async_ready", 64'(in_ready),  64'h1);
        model_reset();
        #2;
        rst_n = 1'b1;
        idle("t6.post", 1);
        send("t6.d2", 4'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
